// File: rtl/lfsr_stats.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lfsr_stats : parametrised Fibonacci LFSR with window ones/zeros statistics
//              and period measurement back to the start state.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module lfsr_stats #(
  parameter int                WIDTH  = 13,
  parameter logic [WIDTH-1:0]  TAPS   = 13'h100D,
  parameter logic [WIDTH-1:0]  SEED   = 13'h100D,
  parameter int                WINDOW = 8191,
  parameter int                CNT_W  = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] lfsr_state,
  output logic             lfsr_out,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] zeros_cnt,
  output logic             window_done,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             seed_fixed
);

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] start_val;
  logic [CNT_W-1:0] acc_one;
  logic [CNT_W-1:0] acc_zero;
  logic [CNT_W-1:0] win_ctr;
  logic [CNT_W-1:0] period_ctr;

  logic             feedback;
  logic [WIDTH-1:0] next_state;
  logic             bit_b;
  logic [CNT_W-1:0] inc_one;
  logic [CNT_W-1:0] inc_zero;
  logic             win_last;
  logic             period_hit;
  logic             seed_zero;
  logic [WIDTH-1:0] load_val;

  assign feedback   = ^(state & TAPS);
  assign next_state = {state[WIDTH-2:0], feedback};
  assign bit_b      = state[WIDTH-1];
  assign inc_one    = {{(CNT_W-1){1'b0}}, bit_b};
  assign inc_zero   = {{(CNT_W-1){1'b0}}, ~bit_b};
  assign win_last   = (win_ctr == WIN_LAST);
  assign period_hit = (next_state == start_val);
  // An all-zero seed would lock the register, so it falls back to SEED.
  assign seed_zero  = (seed_in == '0);
  assign load_val   = seed_zero ? SEED : seed_in;

  assign lfsr_state = state;
  assign lfsr_out   = state[WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SEED;
      start_val    <= SEED;
      acc_one      <= '0;
      acc_zero     <= '0;
      win_ctr      <= '0;
      period_ctr   <= '0;
      ones_cnt     <= '0;
      zeros_cnt    <= '0;
      period       <= '0;
      window_done  <= 1'b0;
      period_valid <= 1'b0;
      seed_fixed   <= 1'b0;
    end else begin
      window_done  <= 1'b0;
      period_valid <= 1'b0;
      seed_fixed   <= 1'b0;
      if (load) begin
        state      <= load_val;
        start_val  <= load_val;
        acc_one    <= '0;
        acc_zero   <= '0;
        win_ctr    <= '0;
        period_ctr <= '0;
        seed_fixed <= seed_zero;
      end else if (en) begin
        state <= next_state;
        // Window statistics include the bit sampled on the closing step.
        if (win_last) begin
          ones_cnt    <= acc_one + inc_one;
          zeros_cnt   <= acc_zero + inc_zero;
          acc_one     <= '0;
          acc_zero    <= '0;
          win_ctr     <= '0;
          window_done <= 1'b1;
        end else begin
          acc_one  <= acc_one + inc_one;
          acc_zero <= acc_zero + inc_zero;
          win_ctr  <= win_ctr + 1'b1;
        end
        if (period_hit) begin
          period       <= period_ctr + 1'b1;
          period_ctr   <= '0;
          period_valid <= 1'b1;
        end else begin
          period_ctr <= period_ctr + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stats.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lfsr_stats : randomised and directed bench for lfsr_stats (two configs)
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_lfsr_stats;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [12:0] seed_a = '0;
  logic [4:0]  seed_b = '0;

  logic [12:0] st_a, ones_a, zeros_a, per_a;
  logic        out_a, wd_a, pv_a, fix_a;
  logic [4:0]  st_b;
  logic [5:0]  ones_b, zeros_b, per_b;
  logic        out_b, wd_b, pv_b, fix_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_stats dut_a (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_a),
    .lfsr_state(st_a), .lfsr_out(out_a), .ones_cnt(ones_a), .zeros_cnt(zeros_a),
    .window_done(wd_a), .period(per_a), .period_valid(pv_a), .seed_fixed(fix_a)
  );

  lfsr_stats #(
    .WIDTH(5), .TAPS(5'b10100), .SEED(5'b00001), .WINDOW(7), .CNT_W(6)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_b),
    .lfsr_state(st_b), .lfsr_out(out_b), .ones_cnt(ones_b), .zeros_cnt(zeros_b),
    .window_done(wd_b), .period(per_b), .period_valid(pv_b), .seed_fixed(fix_b)
  );

  // Reference model parameters and state, index 0 = dut_a, 1 = dut_b.
  int p_w[2], p_taps[2], p_seed[2], p_win[2];
  int m_st[2], m_start[2], m_ones[2], m_steps[2], m_pc[2];
  int e_ones[2], e_zeros[2], e_period[2], e_wd[2], e_pv[2], e_fix[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = p_seed[k]; m_start[k] = p_seed[k];
      m_ones[k] = 0; m_steps[k] = 0; m_pc[k] = 0;
      e_ones[k] = 0; e_zeros[k] = 0; e_period[k] = 0;
      e_wd[k] = 0; e_pv[k] = 0; e_fix[k] = 0;
    end
  endtask

  // Behaviour of one clock edge: count the sampled bit, derive zeros from window size.
  task automatic m_apply(input int k, input bit e, input bit l, input int seed);
    int mask, b, nxt;
    mask = (1 << p_w[k]) - 1;
    e_wd[k] = 0; e_pv[k] = 0; e_fix[k] = 0;
    if (l) begin
      m_st[k] = (seed == 0) ? p_seed[k] : seed;
      m_start[k] = m_st[k];
      m_ones[k] = 0; m_steps[k] = 0; m_pc[k] = 0;
      e_fix[k] = (seed == 0) ? 1 : 0;
    end else if (e) begin
      b = (m_st[k] >> (p_w[k] - 1)) & 1;
      nxt = ((m_st[k] << 1) | ($countones(m_st[k] & p_taps[k]) & 1)) & mask;
      m_ones[k] += b;
      m_steps[k]++;
      if (m_steps[k] == p_win[k]) begin
        e_ones[k] = m_ones[k];
        e_zeros[k] = p_win[k] - m_ones[k];
        m_ones[k] = 0; m_steps[k] = 0; e_wd[k] = 1;
      end
      m_pc[k]++;
      if (nxt == m_start[k]) begin
        e_period[k] = m_pc[k]; m_pc[k] = 0; e_pv[k] = 1;
      end
      m_st[k] = nxt;
    end
  endtask

  task automatic compare_all();
    check("a.state", 32'(st_a), m_st[0]);
    check("a.out", 32'(out_a), (m_st[0] >> 12) & 1);
    check("a.ones", 32'(ones_a), e_ones[0]);
    check("a.zeros", 32'(zeros_a), e_zeros[0]);
    check("a.wdone", 32'(wd_a), e_wd[0]);
    check("a.period", 32'(per_a), e_period[0]);
    check("a.pvalid", 32'(pv_a), e_pv[0]);
    check("a.fixed", 32'(fix_a), e_fix[0]);
    check("b.state", 32'(st_b), m_st[1]);
    check("b.out", 32'(out_b), (m_st[1] >> 4) & 1);
    check("b.ones", 32'(ones_b), e_ones[1]);
    check("b.zeros", 32'(zeros_b), e_zeros[1]);
    check("b.wdone", 32'(wd_b), e_wd[1]);
    check("b.period", 32'(per_b), e_period[1]);
    check("b.pvalid", 32'(pv_b), e_pv[1]);
    check("b.fixed", 32'(fix_b), e_fix[1]);
  endtask

  task automatic cyc(input bit e, input bit l, input int sa, input int sb);
    @(negedge clk);
    en = e; load = l; seed_a = sa[12:0]; seed_b = sb[4:0];
    @(posedge clk);
    #1;
    m_apply(0, e, l, int'(seed_a));
    m_apply(1, e, l, int'(seed_b));
    compare_all();
  endtask

  task automatic async_reset();
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    #2 reset = 1'b1;
    #1;
    m_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  int wd_seen;

  initial begin
    p_w    = '{13, 5};
    p_taps = '{32'h100D, 32'h14};
    p_seed = '{32'h100D, 32'h01};
    p_win  = '{8191, 7};
    m_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1 compare_all();
    @(negedge clk) reset = 1'b0;

    // Full maximal-length window from the reset seed
    repeat (8191) cyc(1, 0, 0, 0);
    check("s1.ones", 32'(ones_a), 4096);
    check("s1.zeros", 32'(zeros_a), 4095);
    check("s1.period", 32'(per_a), 8191);
    check("s1.wdone", 32'(wd_a), 1);
    check("s1.pvalid", 32'(pv_a), 1);
    check("s1.state", 32'(st_a), 32'h100D);

    // Load of a zero seed colliding with the window-final step
    repeat (8190) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    check("ld0.state", 32'(st_a), 32'h100D);
    check("ld0.fixed", 32'(fix_a), 1);
    check("ld0.wdone", 32'(wd_a), 0);
    check("ld0.ones", 32'(ones_a), 4096);
    cyc(1, 0, 0, 0);
    check("ld0.fixed_once", 32'(fix_a), 0);

    // Period measured from a runtime seed of 1
    cyc(1, 1, 1, 3);
    check("ld1.state", 32'(st_a), 1);
    repeat (8191) cyc(1, 0, 0, 0);
    check("ld1.pvalid", 32'(pv_a), 1);
    check("ld1.period", 32'(per_a), 8191);
    check("ld1.state_back", 32'(st_a), 1);

    // Alternating enable: same results after 8191 enabled steps
    async_reset();
    for (int i = 0; i < 16382; i++) cyc(((i & 1) == 0), 0, 0, 0);
    check("s3.ones", 32'(ones_a), 4096);
    check("s3.zeros", 32'(zeros_a), 4095);
    check("s3.period", 32'(per_a), 8191);
    check("s3.state", 32'(st_a), 32'h100D);

    // Asynchronous reset mid-window, then a full window is needed again
    repeat (3000) cyc(1, 0, 0, 0);
    async_reset();
    check("rst.state", 32'(st_a), 32'h100D);
    check("rst.ones", 32'(ones_a), 0);
    wd_seen = 0;
    for (int i = 0; i < 8190; i++) begin
      cyc(1, 0, 0, 0);
      wd_seen += int'(wd_a);
    end
    check("rst.no_early_wdone", wd_seen, 0);
    cyc(1, 0, 0, 0);
    check("rst.wdone", 32'(wd_a), 1);

    // Small config: load exactly on its window-final step
    for (int i = 0; i < 10 && m_steps[1] != 6; i++) cyc(1, 0, 0, 0);
    check("b.at_last_step", m_steps[1], 6);
    cyc(1, 1, 5, 9);
    check("b.ld_wdone", 32'(wd_b), 0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) == 0) ? 0 : int'($urandom),
          ($urandom_range(0, 3) == 0) ? 0 : int'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
